// File: rtl/kalman_pkg.sv
// Shared phase codes, sequencer state encoding and coordinate width default for the Kalman tracker.
// Everything here is constants and pure functions; there is no timing or flow control.
package kalman_pkg;

  localparam int DISP_WIDTH_DEF = 11;

  typedef enum logic [1:0] {
    OP_INIT   = 2'd0,
    OP_PRED   = 2'd1,
    OP_INTERM = 2'd2,
    OP_UPD    = 2'd3
  } mac_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_WAIT   = 3'd2,
    S_PRED   = 3'd3,
    S_INTERM = 3'd4,
    S_UPD    = 3'd5,
    S_OUT    = 3'd6
  } state_e;

  function automatic logic is_phase(input state_e s);
    return (s == S_INIT) || (s == S_PRED) || (s == S_INTERM) || (s == S_UPD);
  endfunction

  function automatic mac_op_e phase_op(input state_e s);
    mac_op_e op;
    case (s)
      S_PRED:   op = OP_PRED;
      S_INTERM: op = OP_INTERM;
      S_UPD:    op = OP_UPD;
      default:  op = OP_INIT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/kalman_seq_if.sv
// Detector-to-sequencer measurement channel: valid/ready handshake carrying one centroid.
// The detector holds valid and data stable until it sees ready; no latency of its own.
interface kalman_seq_if #(
  parameter int DISP_WIDTH = kalman_pkg::DISP_WIDTH_DEF
);
  logic                  meas_valid;
  logic                  meas_ready;
  logic [DISP_WIDTH-1:0] meas_x;
  logic [DISP_WIDTH-1:0] meas_y;

  modport master (output meas_valid, output meas_x, output meas_y, input meas_ready);
  modport slave  (input meas_valid, input meas_x, input meas_y, output meas_ready);
endinterface

// File: rtl/kalman_meas_buf.sv
// One-entry measurement holding register: captures on valid&&ready, z visible the next cycle.
// Ready is low while full; consume or flush empties it, accepts only happen when already empty.
module kalman_meas_buf
  import kalman_pkg::*;
#(
  parameter int W = DISP_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic         consume,
  input  logic         flush,
  output logic         full,
  output logic [W-1:0] z_x,
  output logic [W-1:0] z_y
);

  logic         full_q, full_d;
  logic [W-1:0] z_x_q, z_x_d;
  logic [W-1:0] z_y_q, z_y_d;

  always_comb begin
    full_d = full_q;
    z_x_d  = z_x_q;
    z_y_d  = z_y_q;
    if (consume || flush) begin
      full_d = 1'b0;
    end
    if (in_valid && !full_q) begin
      full_d = 1'b1;
      z_x_d  = in_x;
      z_y_d  = in_y;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      full_q <= 1'b0;
      z_x_q  <= '0;
      z_y_q  <= '0;
    end else begin
      full_q <= full_d;
      z_x_q  <= z_x_d;
      z_y_q  <= z_y_d;
    end
  end

  assign in_ready = !full_q;
  assign full     = full_q;
  assign z_x      = z_x_q;
  assign z_y      = z_y_q;

endmodule

// File: rtl/kalman_seq.sv
// Kalman track sequencer: per frame runs INIT, or PREDICT[/INTERM/UPDATE], est_valid 1 cycle after last mac_done.
// Backpressure via meas_ready (one-entry buffer); phase watchdog built only with KALMAN_SEQ_WATCHDOG_EN.
module kalman_seq
  import kalman_pkg::*;
#(
  parameter int DISP_WIDTH  = DISP_WIDTH_DEF,
  parameter int MAX_MISS    = 8,
  parameter int MAC_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  aresetn,
  kalman_seq_if.slave           meas,
  input  logic                  frame_tick,
  output logic [DISP_WIDTH-1:0] z_x,
  output logic [DISP_WIDTH-1:0] z_y,
  output logic                  mac_start,
  output logic [1:0]            mac_op,
  input  logic                  mac_done,
  input  logic [DISP_WIDTH-1:0] dp_x,
  input  logic [DISP_WIDTH-1:0] dp_y,
  output logic                  est_valid,
  output logic [DISP_WIDTH-1:0] est_x,
  output logic [DISP_WIDTH-1:0] est_y,
  output logic                  tracking,
  output logic                  overrun
);

  localparam int MW = $clog2(MAX_MISS + 1);
  localparam logic [MW-1:0] MISS_LIM = MW'(MAX_MISS);

  state_e                state_q, state_d;
  mac_op_e               mac_op_q, mac_op_d;
  logic                  mac_start_q, mac_start_d;
  logic                  est_valid_q, est_valid_d;
  logic [DISP_WIDTH-1:0] est_x_q, est_x_d;
  logic [DISP_WIDTH-1:0] est_y_q, est_y_d;
  logic                  tracking_q, tracking_d;
  logic                  overrun_q, overrun_d;
  logic [MW-1:0]         miss_q, miss_d;
  logic                  buf_full, buf_consume, buf_flush, capture, wd_fire;

  kalman_meas_buf #(.W(DISP_WIDTH)) u_meas_buf (
    .clk      (clk),
    .aresetn  (aresetn),
    .in_valid (meas.meas_valid),
    .in_ready (meas.meas_ready),
    .in_x     (meas.meas_x),
    .in_y     (meas.meas_y),
    .consume  (buf_consume),
    .flush    (buf_flush),
    .full     (buf_full),
    .z_x      (z_x),
    .z_y      (z_y)
  );

`ifdef KALMAN_SEQ_WATCHDOG_EN
  localparam int TW = $clog2(MAC_TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;

  // Counts cycles spent in the current phase without mac_done; zero outside phases.
  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if (is_phase(state_q) && !mac_done) begin
      wd_d    = wd_q + 1'b1;
      wd_fire = (wd_q == TW'(MAC_TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  // Phases may stall forever; the comparison only keeps MAC_TIMEOUT referenced.
  assign wd_fire = (MAC_TIMEOUT < 0);
`endif

  always_comb begin
    state_d     = state_q;
    mac_op_d    = mac_op_q;
    mac_start_d = 1'b0;
    est_valid_d = 1'b0;
    est_x_d     = est_x_q;
    est_y_d     = est_y_q;
    tracking_d  = tracking_q;
    overrun_d   = 1'b0;
    miss_d      = miss_q;
    buf_consume = 1'b0;
    buf_flush   = 1'b0;
    capture     = 1'b0;

    case (state_q)
      S_IDLE:   if (buf_full) state_d = S_INIT;
      S_INIT: begin
        if (mac_done) begin
          state_d     = S_OUT;
          buf_consume = 1'b1;
          tracking_d  = 1'b1;
          miss_d      = '0;
          capture     = 1'b1;
        end
      end
      S_WAIT:   if (frame_tick) state_d = S_PRED;
      S_PRED: begin
        if (mac_done) begin
          if (buf_full) begin
            state_d = S_INTERM;
          end else begin
            state_d = S_OUT;
            capture = 1'b1;
            if (miss_q != MISS_LIM) miss_d = miss_q + 1'b1;
          end
        end
      end
      S_INTERM: if (mac_done) state_d = S_UPD;
      S_UPD: begin
        if (mac_done) begin
          state_d     = S_OUT;
          buf_consume = 1'b1;
          miss_d      = '0;
          capture     = 1'b1;
        end
      end
      S_OUT: begin
        if (miss_q >= MISS_LIM) begin
          state_d    = S_IDLE;
          tracking_d = 1'b0;
          miss_d     = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      default:  state_d = S_IDLE;
    endcase

    // The estimate lands together with the transition into OUT so est_valid trails mac_done by one cycle.
    if (capture) begin
      est_valid_d = 1'b1;
      est_x_d     = dp_x;
      est_y_d     = dp_y;
    end

    if (frame_tick && (state_q != S_IDLE) && (state_q != S_WAIT)) begin
      overrun_d = 1'b1;
    end

    if (wd_fire) begin
      state_d     = S_IDLE;
      tracking_d  = 1'b0;
      miss_d      = '0;
      buf_flush   = 1'b1;
      capture     = 1'b0;
      est_valid_d = 1'b0;
    end

    if (is_phase(state_d) && (state_d != state_q)) begin
      mac_start_d = 1'b1;
      mac_op_d    = phase_op(state_d);
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      mac_op_q    <= OP_INIT;
      mac_start_q <= 1'b0;
      est_valid_q <= 1'b0;
      est_x_q     <= '0;
      est_y_q     <= '0;
      tracking_q  <= 1'b0;
      overrun_q   <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      mac_op_q    <= mac_op_d;
      mac_start_q <= mac_start_d;
      est_valid_q <= est_valid_d;
      est_x_q     <= est_x_d;
      est_y_q     <= est_y_d;
      tracking_q  <= tracking_d;
      overrun_q   <= overrun_d;
      miss_q      <= miss_d;
    end
  end

  assign mac_start = mac_start_q;
  assign mac_op    = mac_op_q;
  assign est_valid = est_valid_q;
  assign est_x     = est_x_q;
  assign est_y     = est_y_q;
  assign tracking  = tracking_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_kalman_seq.sv
// Bench for kalman_seq: directed frame table, randomized frames against a track/miss model, watchdog and reset cases.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_kalman_seq;
  import kalman_pkg::*;

  localparam int W    = 11;
  localparam int MAXM = 8;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         frame_tick = 1'b0;
  logic         mac_done = 1'b0;
  logic [W-1:0] dp_x = '0, dp_y = '0;
  logic [W-1:0] z_x, z_y, est_x, est_y;
  logic         mac_start, est_valid, tracking, overrun;
  logic [1:0]   mac_op;

  always #5 clk = ~clk;

  kalman_seq_if #(.DISP_WIDTH(W)) meas_if ();

  kalman_seq #(.DISP_WIDTH(W), .MAX_MISS(MAXM), .MAC_TIMEOUT(64)) dut (
    .clk(clk), .aresetn(aresetn), .meas(meas_if), .frame_tick(frame_tick),
    .z_x(z_x), .z_y(z_y), .mac_start(mac_start), .mac_op(mac_op), .mac_done(mac_done),
    .dp_x(dp_x), .dp_y(dp_y), .est_valid(est_valid), .est_x(est_x), .est_y(est_y),
    .tracking(tracking), .overrun(overrun)
  );

  int checks = 0, errors = 0;
  int start_cnt = 0, ovr_cnt = 0, est_cnt = 0;
  bit m_track = 0;
  int m_miss = 0;

  typedef struct {
    bit meas; bit tick; bit mode; logic [W-1:0] x; logic [W-1:0] y;
    int dly; bit inj; logic [1:0] op0; int nops; bit trk;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no response within cycle budget", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (mac_start) start_cnt++;
    if (overrun) ovr_cnt++;
    if (est_valid) est_cnt++;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_ready"}, meas_if.meas_ready, 1);
    chk({nm, "_ctl"}, {mac_start, mac_op, est_valid, tracking, overrun}, 0);
    chk({nm, "_data"}, {z_x, z_y, est_x, est_y}, 0);
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (mac_start) begin ok = 1; break; end
      step();
    end
  endtask

  // One whole frame: offer measurement / tick, answer each phase, then check ops, estimate and track state.
  task automatic do_frame(input bit meas, input bit tick, input bit mode,
                          input logic [W-1:0] x, input logic [W-1:0] y, input int dly,
                          input bit inj, input logic [1:0] op0, input int nops, input bit trk);
    logic [1:0]   ops [8];
    logic [1:0]   o;
    logic [W-1:0] lx, ly;
    int n, d;
    bit got, just_done, stable;
    n = 0; got = 0; just_done = 0; lx = '0; ly = '0;
    start_cnt = 0; ovr_cnt = 0;
    if (meas && !(tick && mode)) begin
      chk("ready_pre", meas_if.meas_ready, 1);
      meas_if.meas_valid = 1; meas_if.meas_x = x; meas_if.meas_y = y;
      step();
      meas_if.meas_valid = 0;
      chk("ready_held", meas_if.meas_ready, 0);
      chk("z_capture", {z_x, z_y}, {x, y});
    end
    if (tick) begin
      if (meas && mode) begin
        chk("ready_coinc", meas_if.meas_ready, 1);
        meas_if.meas_valid = 1; meas_if.meas_x = x; meas_if.meas_y = y;
      end
      frame_tick = 1;
      step();
      frame_tick = 0;
      meas_if.meas_valid = 0;
    end
    for (int c = 0; c < 400 && !got; c++) begin
      if (est_valid) begin
        got = 1;
        chk("est_latency", just_done, 1);
      end else if (mac_start) begin
        o = mac_op;
        if (n < 8) ops[n] = o;
        n++;
        d = (dly < 0) ? int'($urandom_range(4, 0)) : dly;
        stable = 1;
        if (inj && o == 2'd2) frame_tick = 1;
        for (int i = 0; i < d; i++) begin
          step();
          frame_tick = 0;
          if (mac_start || mac_op !== o) stable = 0;
        end
        chk("op_hold", stable, 1);
        lx = W'($urandom); ly = W'($urandom);
        dp_x = lx; dp_y = ly; mac_done = 1;
        step();
        mac_done = 0; frame_tick = 0;
        just_done = 1;
      end else begin
        just_done = 0;
        step();
      end
    end
    if (!got) begin
      fail_to("frame_est");
    end else begin
      chk("est_xy", {est_x, est_y}, {lx, ly});
      chk("trk_at_est", tracking, 1);
      chk("n_ops", n, nops);
      for (int k = 0; k < n && k < 8; k++) chk("op_seq", ops[k], op0 + k);
      est_cnt = 0;
      step();
      chk("est_pulse", est_valid, 0);
      mac_done = 1;
      step();
      mac_done = 0;
      step(); step();
      chk("starts", start_cnt, nops);
      chk("overrun_cnt", ovr_cnt, (inj && nops == 3) ? 1 : 0);
      chk("no_extra_est", est_cnt, 0);
      chk("trk_after", tracking, trk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global time limit");
  end

  initial begin
    bit ok;
    meas_if.meas_valid = 0; meas_if.meas_x = '0; meas_if.meas_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    aresetn = 1;
    step();

    // Directed table: init, full update with overrun, coincident tick/measurement, eight coasts.
    tbl[0] = '{1, 0, 0, 11'd100, 11'd200, 3, 0, 2'd0, 1, 1};
    tbl[1] = '{1, 1, 0, 11'd300, 11'd400, 2, 1, 2'd1, 3, 1};
    tbl[2] = '{1, 1, 1, 11'd5, 11'd2047, 0, 0, 2'd1, 3, 1};
    for (int r = 3; r < 11; r++) tbl[r] = '{0, 1, 0, 11'd0, 11'd0, 1, 0, 2'd1, 1, (r != 10)};
    for (int r = 0; r < 11; r++)
      do_frame(tbl[r].meas, tbl[r].tick, tbl[r].mode, tbl[r].x, tbl[r].y, tbl[r].dly,
               tbl[r].inj, tbl[r].op0, tbl[r].nops, tbl[r].trk);

    m_track = 0; m_miss = 0;
    for (int f = 0; f < 40; f++) begin
      bit meas, tick, mode, inj;
      logic [1:0] op0;
      int nops;
      mode = 1'($urandom);
      if (!m_track) begin
        meas = 1; tick = 1'($urandom); inj = 0; op0 = 2'd0; nops = 1;
        m_track = 1; m_miss = 0;
      end else begin
        meas = ($urandom % 10) < 3; tick = 1; inj = ($urandom % 4) == 0; op0 = 2'd1;
        if (meas) begin
          nops = 3; m_miss = 0;
        end else begin
          nops = 1; m_miss++;
          if (m_miss >= MAXM) m_track = 0;
        end
      end
      do_frame(meas, tick, mode, W'($urandom), W'($urandom), -1, inj, op0, nops, m_track);
    end

    // Stalled PREDICT phase with a fresh track.
    if (!m_track) do_frame(1, 0, 0, 11'd42, 11'd43, -1, 0, 2'd0, 1, 1);
    else do_frame(1, 1, 0, 11'd42, 11'd43, -1, 0, 2'd1, 3, 1);
    frame_tick = 1; step(); frame_tick = 0;
    wait_start(ok);
    if (!ok) fail_to("wd_pred_start");
    chk("wd_op", mac_op, 1);
    start_cnt = 0; est_cnt = 0;
`ifdef KALMAN_SEQ_WATCHDOG_EN
    begin
      int cnt;
      step();
      meas_if.meas_valid = 1; meas_if.meas_x = 11'd7; meas_if.meas_y = 11'd9;
      step();
      meas_if.meas_valid = 0;
      cnt = 2;
      while (tracking && cnt < 200) begin step(); cnt++; end
      chk("wd_cycles", cnt, 64);
      chk("wd_flush_ready", meas_if.meas_ready, 1);
      repeat (4) step();
      chk("wd_no_restart", start_cnt, 0);
      chk("wd_no_est", est_cnt, 0);
      chk("wd_trk", tracking, 0);
    end
`else
    repeat (100) step();
    chk("stall_trk", tracking, 1);
    chk("stall_op", mac_op, 1);
    chk("stall_no_est", est_cnt, 0);
    chk("stall_no_start", start_cnt, 0);
    dp_x = 11'd77; dp_y = 11'd88; mac_done = 1;
    step();
    mac_done = 0;
    chk("stall_est", {est_valid, est_x, est_y}, {1'b1, 11'd77, 11'd88});
    step();
`endif

    // Reset asserted in the middle of UPDATE.
    if (!tracking) do_frame(1, 0, 0, 11'd1, 11'd2, -1, 0, 2'd0, 1, 1);
    meas_if.meas_valid = 1; meas_if.meas_x = 11'd500; meas_if.meas_y = 11'd600;
    step();
    meas_if.meas_valid = 0;
    frame_tick = 1; step(); frame_tick = 0;
    for (int ph = 0; ph < 3; ph++) begin
      wait_start(ok);
      if (!ok) fail_to("rst_phase_start");
      chk("rst_phase_op", mac_op, ph + 1);
      if (ph < 2) begin mac_done = 1; step(); mac_done = 0; end
    end
    step();
    est_cnt = 0; start_cnt = 0;
    aresetn = 0;
    #1;
    chk_reset("rst_upd");
    step(); step();
    aresetn = 1;
    repeat (5) step();
    chk("rst_no_est", est_cnt, 0);
    chk("rst_no_start", start_cnt, 0);
    chk_reset("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
